// File: rtl/usb_evt_sched.sv
// usb_evt_sched -- event serializer and USB transfer scheduler (Clk100 domain).
//
// Each accepted polarity-crossing event (X, Y) is written to the USB FIFO as
// two 16-bit words (X word tagged with bit 14 set, Y word with it clear).
// Completed word pairs are counted as pending and handed to the USB
// controller in batches through oGo/oCnt. A batch is issued when a full
// batch is available, on a frame-end flush, or after an idle timeout.
//
// Build option: define USB_EVT_SCHED_DROP_EN to discard, and count in
// oDropCnt, events offered while the block is not ready. Without it,
// oEvtReady is plain backpressure and oDropCnt stays 0.
module usb_evt_sched #(
    parameter int BATCH_WORDS = 32,     // words per full batch, even, 2..62
    parameter int FIFO_DEPTH  = 1024,   // USB FIFO depth in words
    parameter int TIMEOUT_CYC = 100000  // idle cycles before a partial batch
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEvtValid,
    input  logic        iEvtPol,
    input  logic [9:0]  iEvtX,
    input  logic [9:0]  iEvtY,
    output logic        oEvtReady,
    input  logic        iFrameEnd,
    output logic        oFifoWr,
    output logic [15:0] oFifoD,
    input  logic [9:0]  iFifoUsed,
    input  logic        iFifoFull,
    output logic        oGo,
    output logic [5:0]  oCnt,
    input  logic        iDone,
    output logic        oBusy,
    output logic [15:0] oDropCnt
);

    // The timer only ever needs to reach TIMEOUT_CYC-1.
    localparam int              TmrW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TmrW-1:0] TmrLast  = TmrW'(TIMEOUT_CYC - 1);
    localparam logic [10:0]     BatchLen = 11'(BATCH_WORDS);
    // Room for a full X/Y pair is required before an event is taken.
    localparam logic [9:0]      UsedMax  = 10'(FIFO_DEPTH - 3);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_X    = 2'd1,
        W_Y    = 2'd2
    } wrState_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_GO   = 2'd1,
        D_WAIT = 2'd2
    } dspState_t;

    // ------------------------------------------------------------------
    // Write side: serialize one event into an X word and a Y word
    // ------------------------------------------------------------------
    wrState_t    wrState;
    wrState_t    wrNext;
    logic        evtAccept;
    logic        evtPolQ;
    logic [9:0]  evtYQ;
    logic        fifoWrNxt;
    logic [15:0] fifoDNxt;

    // Ready only when idle and the FIFO can absorb both words; forced low in reset.
    assign oEvtReady = !iRst && (wrState == W_IDLE) && !iFifoFull && (iFifoUsed <= UsedMax);
    assign evtAccept = iEvtValid && oEvtReady;

    // Write FSM state register.
    always_ff @(posedge iClk or posedge iRst) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (iRst) wrState <= W_IDLE;
        else      wrState <= wrNext;
    end

    // Latch the fields still needed after the accept cycle (X goes out straight away).
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            evtPolQ <= 1'b0;
            evtYQ   <= 10'd0;
        end else if (evtAccept) begin
            evtPolQ <= iEvtPol;
            evtYQ   <= iEvtY;
        end
    end

    // Write FSM next state and the next FIFO strobe/data word.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        wrNext    = wrState;
        fifoWrNxt = 1'b0;
        fifoDNxt  = 16'h0000;
        case (wrState)
            W_IDLE: begin
                if (evtAccept) begin
                    wrNext    = W_X;
                    fifoWrNxt = 1'b1;
                    fifoDNxt  = {iEvtPol, 1'b1, 4'b0000, iEvtX};
                end
            end
            W_X: begin
                wrNext    = W_Y;
                fifoWrNxt = 1'b1;
                fifoDNxt  = {evtPolQ, 1'b0, 4'b0000, evtYQ};
            end
            W_Y: begin
                wrNext = W_IDLE;
            end
            default: begin
                wrNext = W_IDLE;
            end
        endcase
    end

    // Registered FIFO write port: X word in W_X, Y word in W_Y.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oFifoWr <= 1'b0;
            oFifoD  <= 16'h0000;
        end else begin
            oFifoWr <= fifoWrNxt;
            oFifoD  <= fifoDNxt;
        end
    end

    // ------------------------------------------------------------------
    // Pending words, trigger conditions and dispatch FSM
    // ------------------------------------------------------------------
    dspState_t       dspState;
    dspState_t       dspNext;
    logic [10:0]     pending;
    logic [10:0]     pendingNext;
    logic            pendingAny;
    logic            wrCredit;
    logic            inFlight;
    logic            fullBatch;
    logic            trigger;
    logic            dispatch;
    logic [10:0]     size;
    logic            flushFlag;
    logic [TmrW-1:0] tmr;

    // A pair is credited only on its Y cycle, so pending stays even.
    assign wrCredit   = (wrState == W_Y);
    assign inFlight   = (wrState != W_IDLE);
    assign pendingAny = (pending != 11'd0);

    // A full batch always takes priority; its size is capped at one batch.
    assign fullBatch = (pending >= BatchLen);
    assign trigger   = fullBatch
                     || (flushFlag && pendingAny)
                     || ((tmr == TmrLast) && pendingAny);
    assign size      = fullBatch ? BatchLen : pending;

    // Dispatch FSM next state; a trigger only counts while idle.
    always_comb begin
        dspNext  = dspState;
        dispatch = 1'b0;
        case (dspState)
            D_IDLE: begin
                if (trigger) begin
                    dispatch = 1'b1;
                    dspNext  = D_GO;
                end
            end
            D_GO: begin
                dspNext = D_WAIT;
            end
            D_WAIT: begin
                if (iDone) dspNext = D_IDLE;
            end
            default: begin
                dspNext = D_IDLE;
            end
        endcase
    end

    // Dispatch FSM state register; reset abandons any transfer in progress.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) dspState <= D_IDLE;
        else      dspState <= dspNext;
    end

    // Credit and debit can land in the same cycle.
    always_comb begin
        pendingNext = pending
                    + (wrCredit ? 11'd2 : 11'd0)
                    - (dispatch ? size  : 11'd0);
    end

    // Pending word counter.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) pending <= 11'd0;
        else      pending <= pendingNext;
    end

    // Flush flag: a new frame end wins; dropped once drained or nothing is owed.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)                                   flushFlag <= 1'b0;
        else if (iFrameEnd)                         flushFlag <= 1'b1;
        else if (dispatch && (size == pending))     flushFlag <= 1'b0;
        else if (!pendingAny && !inFlight)          flushFlag <= 1'b0;
    end

    // Idle timer: runs only in D_IDLE with data owed, frozen during a transfer.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)                          tmr <= '0;
        else if (dispatch || !pendingAny)  tmr <= '0;
        else if (dspState == D_IDLE)       tmr <= tmr + TmrW'(1);
    end

    // Registered controller handshake: Go pulse, held count, busy in D_WAIT.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oGo   <= 1'b0;
            oCnt  <= 6'd0;
            oBusy <= 1'b0;
        end else begin
            oGo   <= dispatch;
            oBusy <= (dspNext == D_WAIT);
            if (dispatch) oCnt <= size[5:0];
        end
    end

    // ------------------------------------------------------------------
    // Optional drop accounting
    // ------------------------------------------------------------------
`ifdef USB_EVT_SCHED_DROP_EN
    // Count events offered while not ready; they are lost, the counter saturates.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)
            oDropCnt <= 16'h0000;
        else if (iEvtValid && !oEvtReady && (oDropCnt != 16'hFFFF))
            oDropCnt <= oDropCnt + 16'd1;
    end
`else
    assign oDropCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_usb_evt_sched.sv
// tb_usb_evt_sched -- self-checking bench for usb_evt_sched.
// A behavioural model (integer pending count, cycles-since-accept counter,
// transfer phase) predicts every output each cycle; directed scenarios add
// end-to-end checks on Go counts, batch sizes and latencies, followed by a
// randomized run.
`timescale 1ns/1ps
module tb_usb_evt_sched;

    localparam int BATCH = 32;
    localparam int DEPTH = 1024;
    localparam int TMO   = 50;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iEvtValid;
    logic        iEvtPol;
    logic [9:0]  iEvtX;
    logic [9:0]  iEvtY;
    logic        oEvtReady;
    logic        iFrameEnd;
    logic        oFifoWr;
    logic [15:0] oFifoD;
    logic [9:0]  iFifoUsed;
    logic        iFifoFull;
    logic        oGo;
    logic [5:0]  oCnt;
    logic        iDone;
    logic        oBusy;
    logic [15:0] oDropCnt;

    always #5 iClk = ~iClk;

    usb_evt_sched #(
        .BATCH_WORDS(BATCH),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iEvtValid(iEvtValid),
        .iEvtPol  (iEvtPol),
        .iEvtX    (iEvtX),
        .iEvtY    (iEvtY),
        .oEvtReady(oEvtReady),
        .iFrameEnd(iFrameEnd),
        .oFifoWr  (oFifoWr),
        .oFifoD   (oFifoD),
        .iFifoUsed(iFifoUsed),
        .iFifoFull(iFifoFull),
        .oGo      (oGo),
        .oCnt     (oCnt),
        .iDone    (iDone),
        .oBusy    (oBusy),
        .oDropCnt (oDropCnt)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s @%0t: observed 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          mSince;   // cycles since the last accepted event, saturating at 3
    bit          mPol;
    logic [9:0]  mX;
    logic [9:0]  mY;
    int          mPend;    // complete words owed to the USB controller
    bit          mFlag;    // flush requested and not yet satisfied
    int          mTmr;     // idle cycles with words owed
    int          mPhase;   // 0 no transfer, 1 Go cycle, 2 waiting for Done
    bit          expWr;
    logic [15:0] expD;
    bit          expGo;
    int          expCnt;
    bit          expBusy;
    int          expDrop;

    // observations of the DUT, used only for scenario bookkeeping
    int cyc     = 0;
    int goSeen  = 0;
    int wrSeen  = 0;
    int goCyc   = 0;
    int accCyc  = 0;
    int doneCyc = 0;
    int cntLog[$];

    function automatic bit modelReady();
        return !iRst && (mSince >= 3) && !iFifoFull && (iFifoUsed <= DEPTH - 3);
    endfunction

    function automatic void modelReset();
        mSince = 3; mPol = 1'b0; mX = '0; mY = '0;
        mPend = 0; mFlag = 1'b0; mTmr = 0; mPhase = 0;
        expWr = 1'b0; expD = '0; expGo = 1'b0; expCnt = 0; expBusy = 1'b0; expDrop = 0;
    endfunction

    // One clock: predict from the pre-edge inputs, then compare after the edge.
    task automatic step();
        bit ready;
        bit trig;
        bit inFlight;
        int size;
        #1;
        ready = modelReady();
        check("evt_ready", oEvtReady, ready);
        if (iRst) begin
            modelReset();
        end else begin
            inFlight = (mSince == 1) || (mSince == 2);
            trig = (mPhase == 0) &&
                   ((mPend >= BATCH) || (mFlag && mPend > 0) || (mTmr == TMO - 1 && mPend > 0));
            size = (mPend < BATCH) ? mPend : BATCH;
            if (iFrameEnd)                     mFlag = 1'b1;
            else if (trig && size == mPend)    mFlag = 1'b0;
            else if (mPend == 0 && !inFlight)  mFlag = 1'b0;
            if (trig || mPend == 0) mTmr = 0;
            else if (mPhase == 0)   mTmr = mTmr + 1;
            mPend = mPend + ((mSince == 2) ? 2 : 0) - (trig ? size : 0);
            if (mPhase == 0)      mPhase = trig ? 1 : 0;
            else if (mPhase == 1) mPhase = 2;
            else if (iDone)       mPhase = 0;
            expGo = trig;
            if (trig) expCnt = size;
            expBusy = (mPhase == 2);
`ifdef USB_EVT_SCHED_DROP_EN
            if (iEvtValid && !ready && expDrop < 65535) expDrop = expDrop + 1;
`endif
            if (iEvtValid && ready) begin
                mSince = 1; mPol = iEvtPol; mX = iEvtX; mY = iEvtY;
            end else if (mSince < 3) begin
                mSince = mSince + 1;
            end
            expWr = (mSince == 1) || (mSince == 2);
            expD  = (mSince == 1) ? {mPol, 1'b1, 4'b0000, mX} : {mPol, 1'b0, 4'b0000, mY};
        end
        @(posedge iClk);
        cyc++;
        #1;
        check("fifo_wr", oFifoWr, expWr);
        if (expWr) check("fifo_d", oFifoD, expD);
        check("go", oGo, expGo);
        check("cnt", oCnt, expCnt);
        check("busy", oBusy, expBusy);
        check("drop_cnt", oDropCnt, expDrop);
        if (oGo) begin
            goSeen++;
            goCyc = cyc;
            cntLog.push_back(int'(oCnt));
        end
        if (oFifoWr) wrSeen++;
        @(negedge iClk);
    endtask

    task automatic clearObs();
        goSeen = 0;
        wrSeen = 0;
        cntLog.delete();
    endtask

    task automatic doReset();
        iRst = 1'b1; iEvtValid = 1'b0; iFrameEnd = 1'b0; iDone = 1'b0;
        iFifoUsed = 10'd0; iFifoFull = 1'b0;
        step();
        step();
        iRst = 1'b0;
        step();
        clearObs();
    endtask

    // Offer one event once the model says ready, then idle for gap cycles.
    task automatic sendEvent(input int gap);
        int guard;
        guard = 0;
        iEvtValid = 1'b0;
        while (!modelReady() && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) check("evt_ready_bound", oEvtReady, 1);
        iEvtValid = 1'b1;
        iEvtPol   = 1'($urandom);
        iEvtX     = 10'($urandom);
        iEvtY     = 10'($urandom);
        step();
        accCyc    = cyc;
        iEvtValid = 1'b0;
        repeat (gap) step();
    endtask

    // Act as the USB controller: wait for busy, then pulse Done after delay cycles.
    task automatic finishXfer(input int delay);
        int guard;
        guard = 0;
        while (!oBusy && guard < 200) begin
            step();
            guard++;
        end
        check("busy_wait_bound", oBusy, 1);
        repeat (delay) step();
        iDone = 1'b1;
        step();
        doneCyc = cyc;
        iDone = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int goBefore;
        int guard;
        modelReset();
        iEvtPol = 1'b0; iEvtX = '0; iEvtY = '0;

        // ---- reset state ----
        iRst = 1'b1; iEvtValid = 1'b1; iFrameEnd = 1'b0; iDone = 1'b0;
        iFifoUsed = 10'd0; iFifoFull = 1'b0;
        step();
        check("reset_ready", oEvtReady, 0);
        check("reset_go", oGo, 0);
        check("reset_cnt", oCnt, 0);
        check("reset_busy", oBusy, 0);
        check("reset_wr", oFifoWr, 0);
        doReset();

        // ---- full batch: 16 back-to-back events ----
        repeat (16) sendEvent(0);
        finishXfer(10);
        repeat (20) step();
        check("batch_go_count", goSeen, 1);
        if (cntLog.size() > 0) check("batch_cnt", cntLog[0], 32);
        check("batch_writes", wrSeen, 32);
        iFrameEnd = 1'b1; step(); iFrameEnd = 1'b0;
        repeat (10) step();
        check("batch_no_extra_go", goSeen, 1);

        // ---- flush ----
        doReset();
        repeat (3) sendEvent(0);
        repeat (3) step();
        iFrameEnd = 1'b1; step(); iFrameEnd = 1'b0;
        finishXfer(5);
        repeat (5) step();
        check("flush_go_count", goSeen, 1);
        if (cntLog.size() > 0) check("flush_cnt", cntLog[0], 6);
        iFrameEnd = 1'b1; step(); iFrameEnd = 1'b0;
        repeat (20) step();
        check("flush_empty_no_go", goSeen, 1);

        // ---- timeout ----
        doReset();
        sendEvent(0);
        guard = 0;
        while (goSeen == 0 && guard < 120) begin
            step();
            guard++;
        end
        check("timeout_go_count", goSeen, 1);
        check("timeout_latency", goCyc - accCyc, 52);
        if (cntLog.size() > 0) check("timeout_cnt", cntLog[0], 2);
        finishXfer(2);
        repeat (3) step();

        // ---- overlap: 20 events, delayed Done, flush during the wait ----
        doReset();
        repeat (20) sendEvent(0);
        repeat (3) step();
        iFrameEnd = 1'b1; step(); iFrameEnd = 1'b0;
        check("overlap_still_busy", oBusy, 1);
        repeat (80) step();
        iDone = 1'b1; step(); doneCyc = cyc; iDone = 1'b0;
        repeat (3) step();
        check("overlap_go_count", goSeen, 2);
        if (cntLog.size() > 1) begin
            check("overlap_cnt_first", cntLog[0], 32);
            check("overlap_cnt_second", cntLog[1], 8);
        end
        check("overlap_go_after_done", goCyc - doneCyc, 1);
        finishXfer(3);
        repeat (3) step();

        // ---- full FIFO and the ready threshold ----
        doReset();
        iFifoUsed = 10'd1021;
        #1;
        check("used_1021_ready", oEvtReady, 1);
        iFifoUsed = 10'd1022;
        iEvtValid = 1'b1; iEvtPol = 1'b1; iEvtX = 10'd123; iEvtY = 10'd456;
        #1;
        check("used_1022_ready", oEvtReady, 0);
        repeat (5) step();
        check("full_no_writes", wrSeen, 0);
`ifdef USB_EVT_SCHED_DROP_EN
        check("full_drop_cnt", oDropCnt, 5);
`else
        check("full_drop_cnt", oDropCnt, 0);
`endif
        iFifoUsed = 10'd1000;
        step();
        iEvtValid = 1'b0;
        repeat (3) step();
        check("full_then_accept_writes", wrSeen, 2);

        // ---- reset during D_WAIT and W_Y ----
        doReset();
        repeat (16) sendEvent(0);
        guard = 0;
        while (!oBusy && guard < 50) begin
            step();
            guard++;
        end
        sendEvent(0);
        step();
        check("pre_rst_busy", oBusy, 1);
        check("pre_rst_wr", oFifoWr, 1);
        #2 iRst = 1'b1;
        #1;
        check("arst_ready", oEvtReady, 0);
        check("arst_wr", oFifoWr, 0);
        check("arst_d", oFifoD, 0);
        check("arst_go", oGo, 0);
        check("arst_cnt", oCnt, 0);
        check("arst_busy", oBusy, 0);
        check("arst_drop", oDropCnt, 0);
        step();
        iRst = 1'b0;
        step();
        goBefore = goSeen;
        iDone = 1'b1; step(); iDone = 1'b0;
        iFrameEnd = 1'b1; step(); iFrameEnd = 1'b0;
        repeat (60) step();
        check("post_rst_no_go", goSeen, goBefore);
        check("post_rst_busy", oBusy, 0);

        // ---- randomized run ----
        doReset();
        begin
            int  doneWait;
            bit  holdEvt;
            int  rstAt;
            doneWait = -1;
            holdEvt  = 1'b0;
            rstAt    = $urandom_range(1500, 2500);
            for (int c = 0; c < 4000; c++) begin
                iRst = (c == rstAt);
                if (iRst) doneWait = -1;
                if (!holdEvt) begin
                    iEvtValid = ($urandom_range(0, 99) < 45);
                    iEvtPol   = 1'($urandom);
                    iEvtX     = 10'($urandom);
                    iEvtY     = 10'($urandom);
                end
                if ($urandom_range(0, 9) == 0) iFifoUsed = 10'($urandom_range(1015, 1023));
                else                           iFifoUsed = 10'($urandom_range(0, 900));
                iFifoFull = ($urandom_range(0, 49) == 0);
                iFrameEnd = ($urandom_range(0, 59) == 0);
                if (mPhase == 2 && doneWait < 0) doneWait = $urandom_range(0, 30);
                iDone = 1'b0;
                if (doneWait == 0) begin
                    iDone    = 1'b1;
                    doneWait = -1;
                end else if (doneWait > 0) begin
                    doneWait--;
                end else if ($urandom_range(0, 99) == 0) begin
                    iDone = 1'b1;
                end
`ifdef USB_EVT_SCHED_DROP_EN
                holdEvt = 1'b0;
`else
                holdEvt = iEvtValid && !modelReady();
`endif
                step();
            end
            iRst = 1'b0; iEvtValid = 1'b0; iFrameEnd = 1'b0; iDone = 1'b0;
            repeat (5) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/usb_evt_sched.md
# usb_evt_sched

Scheduler between the video edge-capture logic and the USB transfer engine. Serializes each polarity-crossing event (X, Y) into two 16-bit words in the USB FIFO, tracks the number of complete words awaiting transfer, and issues batched `Go`/`Cnt` commands to the USB controller. A command is issued on a full batch, on a frame-end flush, or on an idle timeout. Sits on the Clk100 domain, between the capture logic and the USB_FIFO/USB blocks.

## Interface
- `BATCH_WORDS`, 32: words per full batch; even; 2..62.
- `FIFO_DEPTH`, 1024: USB FIFO depth in words.
- `TIMEOUT_CYC`, 100000: idle cycles with pending data before a partial batch is forced.
- `iClk`  in  1  system clock (Clk100).
- `iRst`  in  1  reset. Asynchronous, active-high.
- `iEvtValid`  in  1  event present.
- `iEvtPol`  in  1  crossing polarity (1 = rising above threshold).
- `iEvtX`  in  10  pixel column.
- `iEvtY`  in  10  pixel row.
- `oEvtReady`  out  1  event accepted this cycle when high with `iEvtValid`.
- `iFrameEnd`  in  1  one-cycle flush request (end of field).
- `oFifoWr`  out  1  FIFO write strobe.
- `oFifoD`  out  16  FIFO write data.
- `iFifoUsed`  in  10  FIFO occupancy.
- `iFifoFull`  in  1  FIFO full.
- `oGo`  out  1  one-cycle transfer start to the USB controller.
- `oCnt`  out  6  words in the current transfer; held stable from `oGo` until `iDone`.
- `iDone`  in  1  one-cycle transfer complete from the USB controller.
- `oBusy`  out  1  high while in D_WAIT.
- `oDropCnt`  out  16  events dropped (saturating).

## Operation
- **Write FSM: W_IDLE → W_X → W_Y → W_IDLE.**
  - `oEvtReady` = W_IDLE && !iFifoFull && iFifoUsed ≤ FIFO_DEPTH−3.
  - On accept, the event fields are latched.
  - In W_X: `oFifoWr`=1, `oFifoD` = {pol, 1'b1, 4'b0, X}.
  - In W_Y: `oFifoWr`=1, `oFifoD` = {pol, 1'b0, 4'b0, Y}.
- **Pending counter.** 11 bits; +2 on the W_Y cycle only, so it is always even and a pair is never split across batches.
- **Dispatch FSM: D_IDLE → D_GO → D_WAIT → D_IDLE.**
  - Trigger conditions, evaluated in D_IDLE:
    - pending ≥ BATCH_WORDS;
    - flush flag && pending > 0;
    - timeout counter == TIMEOUT_CYC−1 && pending > 0.
  - On trigger: size = min(pending, BATCH_WORDS) is latched into `oCnt`, pending −= size, and the FSM enters D_GO.
  - D_GO asserts `oGo` for one cycle, then moves to D_WAIT.
  - D_WAIT holds until `iDone`, then returns to D_IDLE.
  - `iDone` outside D_WAIT is ignored.
- **Simultaneous +2 and −size in one cycle:** pending_next = pending + 2 − size.
- **Flush flag.**
  - Set by `iFrameEnd`.
  - Cleared on a dispatch whose size equals the pre-dispatch pending (fully drained).
  - Cleared immediately if pending == 0 and no W_X/W_Y is in flight.
  - A flush during D_WAIT is remembered.
- **Timeout counter.**
  - Counts only in D_IDLE with pending > 0.
  - Clears on dispatch or when pending == 0.
  - Does not count in D_WAIT.
- **Priority:** a full batch wins over flush or timeout in the same cycle. Size is always capped at BATCH_WORDS.
- **Reset values:** `oEvtReady`=0 during reset; every other output 0. Pending, flag and counters are 0; both FSMs are in idle.
  - Reset mid-transfer abandons D_WAIT.
  - FIFO contents are not this block's concern.

## Timing
- Event accepted at cycle T:
  - X word written at T+1, Y word at T+2;
  - `oEvtReady` low at T+1 and T+2;
  - next accept no earlier than T+3;
  - pending updated at T+3.
- Trigger true at cycle D (D_IDLE): `oCnt` valid from D+1, `oGo` high at D+1 only, `oBusy` high from D+2.
- `iDone` at E: `oBusy` low at E+1. The earliest next `oGo` is E+2.
- All outputs are registered except `oEvtReady`, which is combinational from state and FIFO level.

## Configuration
- **`USB_EVT_SCHED_DROP_EN` defined:**
  - A cycle with `iEvtValid`=1 and `oEvtReady`=0 discards the event.
  - `oDropCnt` increments, saturating at 16'hFFFF.
  - Suited to the non-stalling video source.
- **Not defined:**
  - `oEvtReady` is pure backpressure; the source must hold the event.
  - `oDropCnt` is constant 0.

## Test plan
- **Full batch:** 16 events, no stalls → 32 FIFO writes alternating X/Y tag bit; one `oGo` with `oCnt`=32; after `iDone`, pending=0 and no further `oGo`.
- **Flush:** 3 events then `iFrameEnd` → one `oGo` with `oCnt`=6; flag clears; a second `iFrameEnd` with pending 0 → no `oGo`.
- **Timeout:** TIMEOUT_CYC=50, 1 event → `oGo` with `oCnt`=2 exactly 50 idle cycles after the pending update.
- **Overlap:** 20 events, `iDone` delayed 100 cycles → first `oCnt`=32; 8 words accumulate during D_WAIT; with flush, second `oCnt`=8, issued 2 cycles after `iDone`.
- **Full FIFO:** iFifoUsed=1022 held, `iEvtValid` for 5 cycles → no writes. With DROP_EN, `oDropCnt`=5; without it, `oEvtReady`=0 and the event is accepted once iFifoUsed=1000.
- **Reset mid-operation:** assert `iRst` during D_WAIT and W_Y → all outputs 0 asynchronously; after release, pending=0 and a stale `iDone` is ignored.
